// File: rtl/mmio_bus_arbiter.sv
// rtl/mmio_bus_arbiter.sv - two-master MMIO bus arbiter with issue/wait/respond sequencing
//
// Purpose: shares one cs/wr/rd MMIO bus between master 0 (CPU bridge, fixed
// priority) and master 1 (secondary master). A consecutive-grant limit on
// master 0 guarantees a waiting master 1 eventually gets a slot. Each access
// runs IDLE -> ISSUE -> (WAIT x WAIT_CYCLES) -> RESP.
//
// Ports:
//   clk, reset                      clock; asynchronous active-low reset
//   mN_req, mN_wr, mN_addr,
//   mN_wr_data                      request and attributes from master N
//   mN_ack, mN_rd_data              completion pulse and registered read data
//   b_mmio_cs, b_wr, b_rd,
//   b_addr, b_wr_data               bus drive toward mmio_sys
//   b_rd_data                       combinational read data from mmio_sys
//   grant                           one-hot current owner, 00 when idle
module mmio_bus_arbiter #(
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned MAX_CONSEC  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [20:0] m0_addr,
  input  logic [31:0] m0_wr_data,
  output logic        m0_ack,
  output logic [31:0] m0_rd_data,
  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic [20:0] m1_addr,
  input  logic [31:0] m1_wr_data,
  output logic        m1_ack,
  output logic [31:0] m1_rd_data,
  output logic        b_mmio_cs,
  output logic        b_wr,
  output logic        b_rd,
  output logic [20:0] b_addr,
  output logic [31:0] b_wr_data,
  input  logic [31:0] b_rd_data,
  output logic [1:0]  grant
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam bit         HAS_WAIT  = (WAIT_CYCLES != 0);
  localparam logic [2:0] WAIT_LOAD = HAS_WAIT ? 3'(WAIT_CYCLES - 1) : 3'd0;
  localparam logic [3:0] MAX_C     = 4'(MAX_CONSEC);

  state_t      state, state_next;
  logic [3:0]  consec;
  logic [2:0]  wait_cnt;
  logic        lat_wr;
  logic [20:0] lat_addr;
  logic [31:0] lat_wr_data;
  logic        pick_m0, pick_m1;
  logic        capture;

  // Master 0 wins unless master 1 is waiting and master 0 has used up its
  // run of consecutive grants.
  assign pick_m0 = m0_req && (!m1_req || (consec < MAX_C));
  assign pick_m1 = m1_req && !pick_m0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    b_mmio_cs  = 1'b0;
    b_wr       = 1'b0;
    b_rd       = 1'b0;
    b_addr     = '0;
    b_wr_data  = '0;
    m0_ack     = 1'b0;
    m1_ack     = 1'b0;
    capture    = 1'b0;
    case (state)
      S_IDLE: begin
        if (pick_m0 || pick_m1) state_next = S_ISSUE;
      end
      S_ISSUE: begin
        b_mmio_cs = 1'b1;
        b_wr      = lat_wr;
        b_rd      = !lat_wr;
        b_addr    = lat_addr;
        b_wr_data = lat_wr_data;
        if (HAS_WAIT) begin
          state_next = S_WAIT;
        end else begin
          state_next = S_RESP;
          capture    = !lat_wr;
        end
      end
      S_WAIT: begin
        // Bus held selected with strobes low so exactly one strobe per access.
        b_mmio_cs = 1'b1;
        b_addr    = lat_addr;
        b_wr_data = lat_wr_data;
        if (wait_cnt == 3'd0) begin
          state_next = S_RESP;
          capture    = !lat_wr;
        end
      end
      S_RESP: begin
        m0_ack     = grant[0];
        m1_ack     = grant[1];
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant       <= '0;
      consec      <= '0;
      wait_cnt    <= '0;
      lat_wr      <= 1'b0;
      lat_addr    <= '0;
      lat_wr_data <= '0;
      m0_rd_data  <= '0;
      m1_rd_data  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_m0 || pick_m1) begin
            grant       <= {pick_m1, pick_m0};
            lat_wr      <= pick_m0 ? m0_wr      : m1_wr;
            lat_addr    <= pick_m0 ? m0_addr    : m1_addr;
            lat_wr_data <= pick_m0 ? m0_wr_data : m1_wr_data;
            // Only master-0 wins that pass over a waiting master 1 count.
            if (pick_m0 && m1_req) begin
              if (consec != MAX_C) consec <= consec + 4'd1;
            end else begin
              consec <= '0;
            end
          end
        end
        S_ISSUE: wait_cnt <= WAIT_LOAD;
        S_WAIT:  if (wait_cnt != 3'd0) wait_cnt <= wait_cnt - 3'd1;
        S_RESP:  grant <= '0;
        default: ;
      endcase
      // Read data goes straight into the owner's register so it is valid in RESP.
      if (capture) begin
        if (grant[0]) m0_rd_data <= b_rd_data;
        if (grant[1]) m1_rd_data <= b_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// tb/tb_mmio_bus_arbiter.sv - scoreboard bench for mmio_bus_arbiter (WAIT_CYCLES 0 and 3)
module tb_mmio_bus_arbiter;

  localparam int W0   = 0;
  localparam int W1   = 3;
  localparam int MAXC = 4;

  typedef struct {
    logic        wr;
    logic [20:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n   [2];
  logic        m_req   [2][2];
  logic        m_wr    [2][2];
  logic [20:0] m_addr  [2][2];
  logic [31:0] m_wd    [2][2];
  logic        m_ack   [2][2];
  logic [31:0] m_rd    [2][2];
  logic        b_cs    [2];
  logic        b_wr    [2];
  logic        b_rd    [2];
  logic [20:0] b_addr  [2];
  logic [31:0] b_wd    [2];
  logic [31:0] b_rdd   [2];
  logic [1:0]  grant   [2];
  logic        ovr_en  [2];
  logic [31:0] ovr_val [2];

  int   errors = 0;
  int   checks = 0;
  txn_t sbq [4][$];
  int   glog [$];
  bit   log_en = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_fn(input logic [20:0] a);
    return {a[10:0], a} ^ 32'h5EED_C0DE;
  endfunction

  function automatic int wc(input int d);
    return (d == 0) ? W0 : W1;
  endfunction

  assign b_rdd[0] = ovr_en[0] ? ovr_val[0] : rd_fn(b_addr[0]);
  assign b_rdd[1] = ovr_en[1] ? ovr_val[1] : rd_fn(b_addr[1]);

  mmio_bus_arbiter #(.WAIT_CYCLES(W0), .MAX_CONSEC(MAXC)) u_dut0 (
    .clk(clk), .reset(rst_n[0]),
    .m0_req(m_req[0][0]), .m0_wr(m_wr[0][0]), .m0_addr(m_addr[0][0]), .m0_wr_data(m_wd[0][0]),
    .m0_ack(m_ack[0][0]), .m0_rd_data(m_rd[0][0]),
    .m1_req(m_req[0][1]), .m1_wr(m_wr[0][1]), .m1_addr(m_addr[0][1]), .m1_wr_data(m_wd[0][1]),
    .m1_ack(m_ack[0][1]), .m1_rd_data(m_rd[0][1]),
    .b_mmio_cs(b_cs[0]), .b_wr(b_wr[0]), .b_rd(b_rd[0]), .b_addr(b_addr[0]),
    .b_wr_data(b_wd[0]), .b_rd_data(b_rdd[0]), .grant(grant[0])
  );

  mmio_bus_arbiter #(.WAIT_CYCLES(W1), .MAX_CONSEC(MAXC)) u_dut1 (
    .clk(clk), .reset(rst_n[1]),
    .m0_req(m_req[1][0]), .m0_wr(m_wr[1][0]), .m0_addr(m_addr[1][0]), .m0_wr_data(m_wd[1][0]),
    .m0_ack(m_ack[1][0]), .m0_rd_data(m_rd[1][0]),
    .m1_req(m_req[1][1]), .m1_wr(m_wr[1][1]), .m1_addr(m_addr[1][1]), .m1_wr_data(m_wd[1][1]),
    .m1_ack(m_ack[1][1]), .m1_rd_data(m_rd[1][1]),
    .b_mmio_cs(b_cs[1]), .b_wr(b_wr[1]), .b_rd(b_rd[1]), .b_addr(b_addr[1]),
    .b_wr_data(b_wd[1]), .b_rd_data(b_rdd[1]), .grant(grant[1])
  );

  function automatic void chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endfunction

  task automatic check_zero(input int d, input string nm);
    logic [63:0] v;
    v = {4'b0, grant[d], b_cs[d], b_wr[d], b_rd[d], b_addr[d], b_wd[d], m_ack[d][0], m_ack[d][1]};
    chk(v == 64'd0, {nm, "_bus"}, v, 64'd0);
    chk(m_rd[d][0] == 32'd0 && m_rd[d][1] == 32'd0, {nm, "_rd"}, {m_rd[d][1], m_rd[d][0]}, 64'd0);
  endtask

  // Monitor state: reference arbitration model and in-flight transaction per DUT.
  bit          busy     [2];
  int          owner    [2];
  int          start    [2];
  int          nstb     [2];
  int          consec_m [2];
  logic        prev_req [2][2];
  logic [31:0] last_rd  [2][2];
  txn_t        cur      [2];
  int          cyc = 0;

  task automatic mon_step(input int d);
    int          w, o;
    logic [1:0]  eg;
    bit          any_ack;
    if (rst_n[d] !== 1'b1) begin
      busy[d] = 1'b0; consec_m[d] = 0;
      prev_req[d][0] = 1'b0; prev_req[d][1] = 1'b0;
      last_rd[d][0] = 32'd0; last_rd[d][1] = 32'd0;
      sbq[2*d].delete(); sbq[2*d+1].delete();
      return;
    end
    any_ack = m_ack[d][0] | m_ack[d][1];
    chk(!(b_wr[d] && b_rd[d]), "both_strobes", 64'({b_wr[d], b_rd[d]}), 64'd0);
    chk(!(m_ack[d][0] && m_ack[d][1]), "both_acks", 64'({m_ack[d][1], m_ack[d][0]}), 64'd0);
    if (!busy[d] && grant[d] != 2'b00) begin
      w  = (prev_req[d][0] && (!prev_req[d][1] || consec_m[d] < MAXC)) ? 0 : 1;
      eg = (w == 0) ? 2'b01 : 2'b10;
      chk(grant[d] == eg, "grant_winner", 64'(grant[d]), 64'(eg));
      if (w == 0) consec_m[d] = prev_req[d][1] ? ((consec_m[d] < MAXC) ? consec_m[d] + 1 : MAXC) : 0;
      else        consec_m[d] = 0;
      if (d == 0 && log_en) glog.push_back(w);
      chk(sbq[2*d+w].size() != 0, "grant_without_request", 64'(grant[d]), 64'd0);
      if (sbq[2*d+w].size() != 0) begin
        busy[d] = 1'b1; owner[d] = w; start[d] = cyc; nstb[d] = 0;
        cur[d] = sbq[2*d+w][0];
      end
    end
    if (busy[d]) begin
      if (b_wr[d] || b_rd[d]) begin
        nstb[d]++;
        chk(cyc == start[d], "strobe_cycle", 64'(cyc - start[d]), 64'd0);
        chk(b_wr[d] == cur[d].wr && b_rd[d] == !cur[d].wr, "strobe_dir",
            64'({b_wr[d], b_rd[d]}), 64'({cur[d].wr, !cur[d].wr}));
        if (cur[d].wr) chk(b_wd[d] == cur[d].wd, "bus_wr_data", 64'(b_wd[d]), 64'(cur[d].wd));
      end
      if (b_cs[d]) chk(b_addr[d] == cur[d].addr, "bus_addr", 64'(b_addr[d]), 64'(cur[d].addr));
      if (cyc > start[d] && cyc <= start[d] + wc(d)) chk(b_cs[d] == 1'b1, "cs_in_wait", 64'(b_cs[d]), 64'd1);
      if (any_ack) begin
        o = owner[d];
        chk(m_ack[d][o] && !m_ack[d][1-o], "ack_owner",
            64'({m_ack[d][1], m_ack[d][0]}), (o == 0) ? 64'd1 : 64'd2);
        chk(cyc - start[d] == 1 + wc(d), "grant_to_ack", 64'(cyc - start[d]), 64'(1 + wc(d)));
        chk(nstb[d] == 1, "strobe_count", 64'(nstb[d]), 64'd1);
        if (!cur[d].wr) last_rd[d][o] = cur[d].rd;
        chk(m_rd[d][o] == last_rd[d][o], "rd_data_owner", 64'(m_rd[d][o]), 64'(last_rd[d][o]));
        chk(m_rd[d][1-o] == last_rd[d][1-o], "rd_data_other", 64'(m_rd[d][1-o]), 64'(last_rd[d][1-o]));
        void'(sbq[2*d+o].pop_front());
        busy[d] = 1'b0;
      end
    end else begin
      chk(!(b_cs[d] || b_wr[d] || b_rd[d]), "bus_idle", 64'({b_cs[d], b_wr[d], b_rd[d]}), 64'd0);
      chk(!any_ack, "ack_idle", 64'({m_ack[d][1], m_ack[d][0]}), 64'd0);
    end
    prev_req[d][0] = m_req[d][0];
    prev_req[d][1] = m_req[d][1];
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) mon_step(d);
    cyc++;
  end

  // Called at posedge+1; returns at posedge+1 after the ack cycle.
  task automatic do_txn(input int d, input int m, input logic wr, input logic [20:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input bit hold,
                        input int exp_lat);
    txn_t t;
    int   n;
    bit   got;
    t.wr = wr; t.addr = a; t.wd = wd; t.rd = exp_rd;
    sbq[2*d+m].push_back(t);
    m_wr[d][m] = wr; m_addr[d][m] = a; m_wd[d][m] = wd; m_req[d][m] = 1'b1;
    n = 0; got = 1'b0;
    while (!got && n < 200) begin
      @(negedge clk);
      if (m_ack[d][m]) got = 1'b1;
      else             n++;
    end
    chk(got, "ack_timeout", 64'(n), 64'd0);
    if (got && exp_lat >= 0) chk(n == exp_lat, "req_to_ack", 64'(n), 64'(exp_lat));
    @(posedge clk); #1;
    if (!hold) m_req[d][m] = 1'b0;
  endtask

  task automatic run_master(input int d, input int m, input int n, input int max_gap);
    for (int i = 0; i < n; i++) begin
      logic        wr;
      logic [20:0] a;
      logic [31:0] wd;
      int          gap;
      wr  = 1'($urandom);
      a   = 21'($urandom);
      wd  = $urandom;
      gap = (i == n - 1) ? 1 : int'($urandom_range(0, max_gap));
      do_txn(d, m, wr, a, wd, rd_fn(a), gap == 0, -1);
      if (gap > 1) begin
        repeat (gap - 1) @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    int n;
    txn_t t;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; ovr_en[d] = 1'b0; ovr_val[d] = 32'd0;
      for (int m = 0; m < 2; m++) begin
        m_req[d][m] = 1'b0; m_wr[d][m] = 1'b0; m_addr[d][m] = '0; m_wd[d][m] = '0;
      end
    end
    #12;
    check_zero(0, "reset0");
    check_zero(1, "reset1");
    @(posedge clk); #1;
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single read, no wait states.
    ovr_en[0] = 1'b1; ovr_val[0] = 32'hDEADBEEF;
    do_txn(0, 0, 1'b0, 21'h00010, 32'd0, 32'hDEADBEEF, 1'b0, 2);
    ovr_en[0] = 1'b0;

    // Single write by master 1 at the top address.
    do_txn(0, 1, 1'b1, 21'h1FFFFF, 32'h12345678, 32'd0, 1'b0, 2);

    // Attribute change during ISSUE must not reach the bus.
    fork
      do_txn(0, 0, 1'b0, 21'h00004, 32'd0, rd_fn(21'h00004), 1'b0, 2);
      begin
        @(posedge clk); #1;
        m_addr[0][0] = 21'h00008;
        #3;
        chk(b_addr[0] == 21'h00004, "issue_addr_latched", 64'(b_addr[0]), 64'h4);
      end
    join

    // Contention: both masters request continuously for 20 transactions.
    log_en = 1'b1;
    fork
      run_master(0, 0, 16, 0);
      run_master(0, 1, 4, 0);
    join
    log_en = 1'b0;
    chk(glog.size() == 20, "contention_len", 64'(glog.size()), 64'd20);
    for (int i = 0; i < glog.size(); i++)
      chk(glog[i] == ((i % 5 == 4) ? 1 : 0), "contention_order", 64'(glog[i]), 64'((i % 5 == 4) ? 1 : 0));

    // Randomized traffic on both arbiters.
    fork
      run_master(0, 0, 12, 3);
      run_master(0, 1, 12, 3);
      run_master(1, 0, 10, 3);
      run_master(1, 1, 10, 3);
    join

    // Three wait states; read data changes in the second wait cycle.
    fork
      do_txn(1, 0, 1'b0, 21'h00123, 32'd0, 32'hA5A5A5A5, 1'b0, 5);
      begin
        ovr_en[1] = 1'b1; ovr_val[1] = 32'h11111111;
        repeat (3) @(posedge clk);
        #1;
        ovr_val[1] = 32'hA5A5A5A5;
      end
    join
    ovr_en[1] = 1'b0;

    // Reset asserted mid-WAIT drops the access without an ack.
    t.wr = 1'b0; t.addr = 21'h0ABCD; t.wd = 32'd0; t.rd = rd_fn(21'h0ABCD);
    sbq[3].push_back(t);
    m_wr[1][1] = 1'b0; m_addr[1][1] = 21'h0ABCD; m_req[1][1] = 1'b1;
    @(posedge clk);
    @(posedge clk); #3;
    chk(grant[1] == 2'b10, "pre_reset_grant", 64'(grant[1]), 64'd2);
    rst_n[1] = 1'b0;
    #1;
    check_zero(1, "async_reset");
    m_req[1][1] = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n[1] = 1'b1;
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (m_ack[1][0] || m_ack[1][1]) n++;
    end
    chk(n == 0, "no_ack_after_reset", 64'(n), 64'd0);
    @(posedge clk); #1;
    do_txn(1, 1, 1'b0, 21'h0ABCD, 32'd0, rd_fn(21'h0ABCD), 1'b0, 5);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mmio_bus_arbiter.md
Name: mmio_bus_arbiter

Overview:
- Two-master arbiter that shares the basic MMIO bus (cs/wr/rd, 21-bit address, 32-bit data) between the CPU-side bridge (master 0) and a secondary master (master 1), such as a UART debug loader.
- Sits between the bridge and mmio_sys.
- Sequences each access as issue, wait, then respond, and returns a registered read-data/ack handshake to the winning master.
- Master 0 has fixed priority, bounded by an anti-starvation counter.

Parameters:
- WAIT_CYCLES, 0, extra bus-hold cycles after the strobe cycle before read data is sampled (0..7).
- MAX_CONSEC, 4, maximum back-to-back master-0 grants while master 1 is pending (1..15).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- m0_req  in  1  master 0 transaction request; held until m0_ack.
- m0_wr  in  1  master 0 direction: 1 = write, 0 = read.
- m0_addr  in  21  master 0 word address.
- m0_wr_data  in  32  master 0 write data.
- m0_ack  out  1  one-cycle completion pulse to master 0.
- m0_rd_data  out  32  registered read data; valid when m0_ack = 1.
- m1_req, m1_wr, m1_addr, m1_wr_data, m1_ack, m1_rd_data: same widths and meaning, for master 1.
- b_mmio_cs  out  1  bus chip select.
- b_wr  out  1  bus write strobe.
- b_rd  out  1  bus read strobe.
- b_addr  out  21  bus address.
- b_wr_data  out  32  bus write data.
- b_rd_data  in  32  bus read data (combinational from mmio_sys).
- grant  out  2  one-hot current owner; 00 when idle.

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE, grant = 00.
  - All bus outputs 0, both acks 0, both rd_data 0.
  - consec counter = 0, wait counter = 0.
  - An in-flight transaction is dropped with no ack; the master must re-request.
- State IDLE:
  - Sample requests.
  - Winner selection:
    - m0 if m0_req and (!m1_req or consec < MAX_CONSEC).
    - Otherwise m1 if m1_req.
  - On a winner:
    - Latch the winner's wr/addr/wr_data into internal registers and set grant.
    - Move to ISSUE next cycle.
  - With no request, stay in IDLE; bus outputs are 0.
- Consec counter:
  - Increments on an m0 grant while m1_req = 1, saturating at MAX_CONSEC.
  - Clears on any m1 grant, or on an m0 grant while m1_req = 0.
- State ISSUE (exactly 1 cycle):
  - b_mmio_cs = 1; b_wr = latched wr; b_rd = !latched wr.
  - b_addr and b_wr_data driven from the latched registers.
  - Next state: WAIT if WAIT_CYCLES > 0 (wait counter loaded with WAIT_CYCLES - 1), else RESP.
  - If WAIT_CYCLES = 0 and the access is a read, capture b_rd_data at the end of ISSUE.
- State WAIT:
  - b_mmio_cs = 1 and b_addr held; b_wr = b_rd = 0.
  - Wait counter decrements each cycle.
  - On counter = 0: capture b_rd_data (reads only) and go to RESP.
- State RESP (1 cycle):
  - The owner's mN_ack = 1.
  - Owner's mN_rd_data is updated with the captured value on reads; it holds its previous value on writes.
  - All bus strobes 0.
  - grant clears to 00 at the next state; go to IDLE.
- Strobe discipline:
  - Exactly one b_wr or b_rd pulse per transaction.
  - Never both strobes in the same cycle.
  - Never a strobe outside ISSUE.
- Latency, request to ack:
  - Request first sampled in IDLE at cycle N gives ack at cycle N + 2 + WAIT_CYCLES.
  - Back-to-back throughput is one transaction per 3 + WAIT_CYCLES cycles.
- Request stability:
  - A master keeps req and its attributes stable until its ack.
  - Attribute changes after the IDLE grant cycle are ignored (latched copy is used).
  - A request deasserted before ack, after grant, still completes; the ack is issued regardless.
- A master holding req high through its ack is re-sampled in the IDLE cycle that follows.
- Simultaneous requests use the priority rule above. With MAX_CONSEC = 4 and both masters continuously requesting, the grant order is m0, m0, m0, m0, m1, repeating.
- The non-owner's ack is always 0, and its rd_data is unchanged.

Test Plan:
- Single read (WAIT_CYCLES = 0): m0 reads addr 0x00010 with b_rd_data = 0xDEADBEEF.
  - b_rd = 1 for exactly 1 cycle with b_addr = 0x00010.
  - m0_ack at request cycle + 2, with m0_rd_data = 0xDEADBEEF.
- Single write by m1: addr 0x1FFFFF, data 0x12345678.
  - One b_wr pulse with matching b_addr and b_wr_data; b_rd stays 0.
  - m1_ack pulses once; m1_rd_data unchanged.
- Contention (MAX_CONSEC = 4): both masters hold req for 20 transactions.
  - Grant sequence is m0 ×4, m1 ×1, repeating.
  - No cycle has both acks set.
- WAIT_CYCLES = 3 read: b_rd_data changes to 0xA5A5A5A5 in the second wait cycle.
  - Captured value is 0xA5A5A5A5.
  - Ack arrives at request cycle + 5.
- Reset mid-WAIT: assert reset in the WAIT state.
  - All outputs are 0 immediately, asynchronously; no ack is ever issued.
  - After release, a re-issued m1 read completes normally.
- Attribute change: m0 changes m0_addr from 0x00004 to 0x00008 in the ISSUE cycle.
  - Bus still shows 0x00004 for the whole transaction.
